rf_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 32×32 general register file. Two sources share its single write port: the main pipeline writeback stage and the multi-cycle multiply/divide unit (MDU) result path. A one-entry result buffer, per-register busy bits, and a decode-stage stall signal keep out-of-order MDU results coherent. The block drives the register file's write address, write data and write-enable inputs directly.

---
 rtl/rf_wb_arbiter_pkg.sv | 22 ++
 rtl/rf_wb_arbiter_if.sv | 50 +++++
 rtl/rf_wb_arbiter_scoreboard.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
// Pure declarations, no logic and no latency.
// No flow control of its own.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    // Wide enough for STARVE_LIMIT up to 15.
    localparam int WAIT_CNT_W = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // IDLE: buffer empty, HELD: buffer full and waiting, FORCE: buffer takes the port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline writeback, MDU result, decode lookup and register-file write signals.
// Wires only, no latency.
// Backpressure is carried by wb_hold (pipeline) and mdu_ack (MDU).
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic      wb_valid;
    reg_addr_t wb_addr;
    reg_data_t wb_data;
    logic      wb_hold;

    logic      mdu_issue;
    reg_addr_t mdu_issue_addr;
    logic      mdu_req;
    reg_addr_t mdu_addr;
    reg_data_t mdu_data;
    logic      mdu_ack;

    reg_addr_t dec_a1;
    reg_addr_t dec_a2;
    reg_addr_t dec_a3;
    logic      dec_stall;

    logic      rf_we;
    reg_addr_t rf_a3;
    reg_data_t rf_wd;

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        output wb_hold,
        input  mdu_issue, mdu_issue_addr, mdu_req, mdu_addr, mdu_data,
        output mdu_ack,
        input  dec_a1, dec_a2, dec_a3,
        output dec_stall,
        output rf_we, rf_a3, rf_wd
    );

    // Pipeline / MDU / register-file side.
    modport master (
        output wb_valid, wb_addr, wb_data,
        input  wb_hold,
        output mdu_issue, mdu_issue_addr, mdu_req, mdu_addr, mdu_data,
        input  mdu_ack,
        output dec_a1, dec_a2, dec_a3,
        input  dec_stall,
        input  rf_we, rf_a3, rf_wd
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register busy bits for outstanding MDU results plus the decode-stage stall lookup.
// Busy bits update on the clock edge; dec_stall is combinational from busy_vec.
// No backpressure; a set and a clear on the same bit resolve to set.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           dec_a1,
    input  reg_addr_t           dec_a2,
    input  reg_addr_t           dec_a3,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                dec_stall
);

    logic [NUM_REGS-1:0] busy_nxt;

    // Clear first so a same-edge set wins; r0 is hardwired never-busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_nxt;
    end

    assign dec_stall = busy_vec[dec_a1] | busy_vec[dec_a2] | busy_vec[dec_a3];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and a one-entry MDU result buffer.
// Pipeline writes pass through with zero latency; a buffered MDU result writes one cycle after transfer at the earliest.
// MDU is acked only when the buffer is empty; with RF_WB_ARB_STARVE_GUARD_EN the buffer forces the port and asserts wb_hold.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    rf_wb_arbiter_if.slave      bus,
    output logic [NUM_REGS-1:0] busy_vec
);

    arb_state_t state;
    arb_state_t state_nxt;
    reg_addr_t  buf_addr;
    reg_data_t  buf_data;
    logic       xfer;
    logic       sel_buf;
    logic       sel_wb;
    logic       hold;
    reg_addr_t  wr_addr;

`ifdef RF_WB_ARB_STARVE_GUARD_EN
    localparam logic [WAIT_CNT_W-1:0] LIMIT_M1 = WAIT_CNT_W'(STARVE_LIMIT - 1);
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
`endif

    assign bus.mdu_ack = (state == ST_IDLE) && !rst;
    assign xfer        = bus.mdu_req && bus.mdu_ack;

    // Port grant and next-state; the pipeline wins unless the buffer is forcing.
    always_comb begin
        sel_buf   = 1'b0;
        sel_wb    = 1'b0;
        hold      = 1'b0;
        state_nxt = state;
`ifdef RF_WB_ARB_STARVE_GUARD_EN
        wait_cnt_nxt = wait_cnt;
        if (state == ST_FORCE) begin
            sel_buf = 1'b1;
            hold    = bus.wb_valid;
        end else
`endif
        if (bus.wb_valid) begin
            sel_wb = 1'b1;
        end else if (state == ST_HELD) begin
            sel_buf = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nxt = ST_HELD;
`ifdef RF_WB_ARB_STARVE_GUARD_EN
                    wait_cnt_nxt = '0;
`endif
                end
            end
            ST_HELD: begin
                if (sel_buf) begin
                    state_nxt = ST_IDLE;
                end else begin
`ifdef RF_WB_ARB_STARVE_GUARD_EN
                    if (wait_cnt == LIMIT_M1) state_nxt = ST_FORCE;
                    else                      wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
`endif
                end
            end
            ST_FORCE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
`ifdef RF_WB_ARB_STARVE_GUARD_EN
            wait_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
`ifdef RF_WB_ARB_STARVE_GUARD_EN
            wait_cnt <= wait_cnt_nxt;
`endif
        end
    end

    // One-entry MDU result buffer, loaded on every accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_addr <= '0;
            buf_data <= '0;
        end else if (xfer) begin
            buf_addr <= bus.mdu_addr;
            buf_data <= bus.mdu_data;
        end
    end

    assign wr_addr     = sel_buf ? buf_addr : bus.wb_addr;
    assign bus.rf_a3   = wr_addr;
    assign bus.rf_wd   = sel_buf ? buf_data : bus.wb_data;
    assign bus.rf_we   = (sel_buf || sel_wb) && (wr_addr != '0) && !rst;
    assign bus.wb_hold = hold && !rst;

    // Busy bit clears on the same edge the buffered result reaches the register file.
    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (bus.mdu_issue),
        .set_addr  (bus.mdu_issue_addr),
        .clr_en    (sel_buf),
        .clr_addr  (buf_addr),
        .dec_a1    (bus.dec_a1),
        .dec_a2    (bus.dec_a2),
        .dec_a3    (bus.dec_a3),
        .busy_vec  (busy_vec),
        .dec_stall (bus.dec_stall)
    );

endmodule
